// File: rtl/h_csr_collector.sv
// Collects one frame of CSR rows from a serial beat stream into registered
// col_idx/value/node_info arrays, then holds the frame until the loader acks.
module h_csr_collector #(
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_OF_COLS     = 5,
  parameter int COL_INDEX_SIZE  = 8,
  parameter int VALUE_SIZE      = 8,
  parameter int NODE_INFO_SIZE  = 5,
  localparam int COL_IDX_WIDTH   = $clog2(NUM_OF_COLS),
  localparam int INDEX_WIDTH     = $clog2(COL_INDEX_SIZE),
  localparam int ROW_LEN_WIDTH   = $clog2(NUM_OF_COLS),
  localparam int NODE_INFO_WIDTH = INDEX_WIDTH + ROW_LEN_WIDTH + 1
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      s_valid_i,
  output logic                                      s_ready_o,
  input  logic                                      s_nz_i,
  input  logic [COL_IDX_WIDTH-1:0]                  s_col_idx_i,
  input  logic [DATA_WIDTH-1:0]                     s_value_i,
  input  logic                                      s_row_last_i,
  input  logic                                      s_flag_i,
  output logic                                      h_valid_o,
  input  logic                                      h_ready_i,
  output logic [COL_INDEX_SIZE*COL_IDX_WIDTH-1:0]   col_idx_o,
  output logic [VALUE_SIZE*DATA_WIDTH-1:0]          value_o,
  output logic [NODE_INFO_SIZE*NODE_INFO_WIDTH-1:0] node_info_o,
  output logic                                      err_o
);

  // nnz_cnt and row_start must reach COL_INDEX_SIZE itself, hence one extra bit.
  localparam int NNZ_W = INDEX_WIDTH + 1;
  localparam int RC_W  = $clog2(NODE_INFO_SIZE + 1);

  // Stream handshake: a beat transfers on a rising clk edge where
  // s_valid_i && s_ready_o; the frame transfers where h_valid_o && h_ready_i.
  typedef enum logic {COLLECT = 1'b0, PRESENT = 1'b1} state_t;

  state_t state, state_next;

  logic [NNZ_W-1:0]         nnz_cnt, row_start, nnz_next;
  logic [ROW_LEN_WIDTH-1:0] row_len, row_len_next;
  logic [RC_W-1:0]          row_cnt;
  logic                     err;

  logic [COL_IDX_WIDTH-1:0]   col_idx_r   [COL_INDEX_SIZE];
  logic [DATA_WIDTH-1:0]      value_r     [VALUE_SIZE];
  logic [NODE_INFO_WIDTH-1:0] node_info_r [NODE_INFO_SIZE];

  logic accept, room, wr, drop, close, frame_done, ack;

  always_comb begin
    accept       = s_valid_i && (state == COLLECT);
    room         = (nnz_cnt < NNZ_W'(COL_INDEX_SIZE)) &&
                   (row_len < ROW_LEN_WIDTH'(NUM_OF_COLS));
    wr           = accept && s_nz_i && room;
    drop         = accept && s_nz_i && !room;
    close        = accept && s_row_last_i;
    nnz_next     = nnz_cnt + NNZ_W'(wr);
    row_len_next = row_len + ROW_LEN_WIDTH'(wr);
    frame_done   = close && (row_cnt == RC_W'(NODE_INFO_SIZE - 1));
    ack          = (state == PRESENT) && h_ready_i;
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (frame_done) state_next = PRESENT;
      PRESENT: if (h_ready_i)  state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nnz_cnt   <= '0;
      row_start <= '0;
      row_len   <= '0;
      row_cnt   <= '0;
      err       <= 1'b0;
    end else if (ack) begin
      nnz_cnt   <= '0;
      row_start <= '0;
      row_len   <= '0;
      row_cnt   <= '0;
      err       <= 1'b0;
    end else begin
      nnz_cnt <= nnz_next;
      if (close) begin
        row_start <= nnz_next;
        row_len   <= '0;
        row_cnt   <= row_cnt + RC_W'(1);
      end else begin
        row_len <= row_len_next;
      end
      if (drop) err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < COL_INDEX_SIZE; i++) col_idx_r[i]   <= '0;
      for (int i = 0; i < VALUE_SIZE; i++)     value_r[i]     <= '0;
      for (int i = 0; i < NODE_INFO_SIZE; i++) node_info_r[i] <= '0;
    end else if (ack) begin
      for (int i = 0; i < COL_INDEX_SIZE; i++) col_idx_r[i]   <= '0;
      for (int i = 0; i < VALUE_SIZE; i++)     value_r[i]     <= '0;
      for (int i = 0; i < NODE_INFO_SIZE; i++) node_info_r[i] <= '0;
    end else begin
      for (int i = 0; i < COL_INDEX_SIZE; i++)
        if (wr && nnz_cnt == NNZ_W'(i)) col_idx_r[i] <= s_col_idx_i;
      for (int i = 0; i < VALUE_SIZE; i++)
        if (wr && nnz_cnt == NNZ_W'(i)) value_r[i] <= s_value_i;
      // row_start keeps only its low bits: an overflowed frame wraps to 0.
      for (int i = 0; i < NODE_INFO_SIZE; i++)
        if (close && row_cnt == RC_W'(i))
          node_info_r[i] <= {row_start[INDEX_WIDTH-1:0], row_len_next, s_flag_i};
    end
  end

  assign s_ready_o = (state == COLLECT);
  assign h_valid_o = (state == PRESENT);
  assign err_o     = err;

  for (genvar g = 0; g < COL_INDEX_SIZE; g++) begin : g_col
    assign col_idx_o[g*COL_IDX_WIDTH +: COL_IDX_WIDTH] = col_idx_r[g];
  end
  for (genvar g = 0; g < VALUE_SIZE; g++) begin : g_val
    assign value_o[g*DATA_WIDTH +: DATA_WIDTH] = value_r[g];
  end
  for (genvar g = 0; g < NODE_INFO_SIZE; g++) begin : g_ni
    assign node_info_o[g*NODE_INFO_WIDTH +: NODE_INFO_WIDTH] = node_info_r[g];
  end

endmodule
